m31_multiplier: RTL and testbench

M31_MULTIPLIER -- requirements
Module: m31_multiplier

---
 rtl/m31_pkg.sv | 8 +
 rtl/multiplier_input_if.sv | 9 +
 rtl/multiplier_output_if.sv | 8 +
 rtl/m31_reduce.sv | 14 +
 rtl/m31_multiplier.sv | 37 +++
 tb/tb_m31_multiplier.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/m31_pkg.sv
// m31_pkg: shared constants and types for the Mersenne-31 multiplier.
package m31_pkg;
    localparam int OPERAND_W = 31;
    localparam int PRODUCT_W = 62;
    localparam logic [OPERAND_W-1:0] M31_P = 31'h7FFF_FFFF;
    typedef logic [OPERAND_W-1:0] operand_t;
    typedef logic [PRODUCT_W-1:0] product_t;
endpackage

// File: rtl/multiplier_input_if.sv
// multiplier_input_if: operand bus.
//   in1, in2 : operands A and B
//   in_valid : operands present this cycle
interface multiplier_input_if #(parameter int INPUT_DATA_WIDTH = 31);
    logic [INPUT_DATA_WIDTH-1:0] in1;
    logic [INPUT_DATA_WIDTH-1:0] in2;
    logic in_valid;
    modport dut (input in1, in2, in_valid);
endinterface

// File: rtl/multiplier_output_if.sv
// multiplier_output_if: result bus.
//   out       : A*B mod P, zero-extended to the full-product width
//   out_valid : out holds a fresh result this cycle
interface multiplier_output_if #(parameter int OUTPUT_DATA_WIDTH = 62);
    logic [OUTPUT_DATA_WIDTH-1:0] out;
    logic out_valid;
    modport dut (output out, out_valid);
endinterface

// File: rtl/m31_reduce.sv
// m31_reduce: combinational reduction of a 62-bit product modulo 2^31-1.
//   p : full product
//   r : canonical residue in [0, P-1]
module m31_reduce
    import m31_pkg::*;
(
    input  product_t p,
    output operand_t r
);
    // 2^31 == 1 mod P, so the high half folds onto the low half; the sum stays below 2P
    logic [OPERAND_W:0] s;
    assign s = {1'b0, p[OPERAND_W-1:0]} + {1'b0, p[PRODUCT_W-1:OPERAND_W]};
    assign r = (s >= {1'b0, M31_P}) ? operand_t'(s - {1'b0, M31_P}) : s[OPERAND_W-1:0];
endmodule

// File: rtl/m31_multiplier.sv
// m31_multiplier: two-stage pipelined multiplier over GF(2^31-1).
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   in_if  : operands in1/in2 with in_valid
//   out_if : residue out with out_valid, two cycles after issue
module m31_multiplier
    import m31_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    multiplier_input_if.dut         in_if,
    multiplier_output_if.dut        out_if
);
    product_t p_q;
    operand_t r_d, r_q;
    logic     v1_q, v2_q;

    m31_reduce u_reduce (.p(p_q), .r(r_d));

    // data registers only load on valid so out holds across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q  <= '0;
            v1_q <= 1'b0;
            r_q  <= '0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= in_if.in_valid;
            v2_q <= v1_q;
            if (in_if.in_valid) p_q <= product_t'(in_if.in1) * product_t'(in_if.in2);
            if (v1_q) r_q <= r_d;
        end
    end

    assign out_if.out       = {{(PRODUCT_W-OPERAND_W){1'b0}}, r_q};
    assign out_if.out_valid = v2_q;
endmodule

// File: tb/tb_m31_multiplier.sv
// tb_m31_multiplier: randomized self-checking bench for m31_multiplier.
module tb_m31_multiplier;
    localparam longint unsigned P = 64'd2147483647;
    localparam int N_RAND = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total = 0;
    logic [61:0] held = '0;

    multiplier_input_if  in_if ();
    multiplier_output_if out_if ();

    m31_multiplier dut (.clk(clk), .rst(rst), .in_if(in_if), .out_if(out_if));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [61:0] ref_mul(logic [30:0] a, logic [30:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return 62'(p % P);
    endfunction

    function automatic logic [30:0] rnd_op();
        int sel;
        sel = $urandom_range(0, 9);
        return sel == 0 ? 31'h7FFF_FFFF : sel == 1 ? 31'd0 : 31'($urandom);
    endfunction

    task automatic drive(bit v, logic [30:0] a, logic [30:0] b);
        in_if.in_valid = v;
        in_if.in1 = a;
        in_if.in2 = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, rnd_op(), rnd_op());
        repeat (3) @(negedge clk);
        total++;
        if (out_if.out_valid !== 1'b0 || out_if.out !== 62'd0)
            $display("FAIL reset_hold: got valid=%0b out=%0d, expected valid=0 out=0", out_if.out_valid, out_if.out);
        else passed++;
        rst = 1'b0;
        drive(1'b0, '0, '0);
        @(negedge clk);
        total++;
        if (out_if.out_valid !== 1'b0 || out_if.out !== 62'd0)
            $display("FAIL reset_release: got valid=%0b out=%0d, expected valid=0 out=0", out_if.out_valid, out_if.out);
        else passed++;
        held = '0;
    endtask

    task automatic test_single();
        drive(1'b1, 31'd686829796, 31'd742061112);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive(1'b0, '0, '0);
            if (i == 2) held = 62'd888237472;
            total++;
            if (out_if.out_valid !== (i == 2) || out_if.out !== held)
                $display("FAIL single_c%0d: got valid=%0b out=%0d, expected valid=%0b out=%0d",
                         i, out_if.out_valid, out_if.out, i == 2, held);
            else passed++;
        end
    endtask

    task automatic test_boundary();
        logic [30:0] a [4] = '{31'd2147483646, 31'd2147483647, 31'd0, 31'd1073741824};
        logic [30:0] b [4] = '{31'd2147483646, 31'd5, 31'd123456, 31'd2};
        logic [61:0] e [4] = '{62'd1, 62'd0, 62'd0, 62'd1};
        bit ev;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ev = i >= 2 && i < 6;
            if (ev) held = e[i-2];
            total++;
            if (out_if.out_valid !== ev || out_if.out !== held)
                $display("FAIL boundary_c%0d: got valid=%0b out=%0d, expected valid=%0b out=%0d",
                         i, out_if.out_valid, out_if.out, ev, held);
            else passed++;
            if (i < 4) drive(1'b1, a[i], b[i]);
            else drive(1'b0, '0, '0);
        end
    endtask

    task automatic test_back_to_back();
        logic [30:0] a [4];
        logic [30:0] b [4];
        bit ev;
        for (int i = 0; i < 4; i++) begin
            a[i] = rnd_op();
            b[i] = rnd_op();
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            ev = i >= 2 && i < 6;
            if (ev) held = ref_mul(a[i-2], b[i-2]);
            total++;
            if (out_if.out_valid !== ev || out_if.out !== held)
                $display("FAIL b2b_c%0d: got valid=%0b out=%0d, expected valid=%0b out=%0d",
                         i, out_if.out_valid, out_if.out, ev, held);
            else passed++;
            if (i < 4) drive(1'b1, a[i], b[i]);
            else drive(1'b0, '0, '0);
        end
    endtask

    task automatic test_bubble();
        bit va [3] = '{1'b1, 1'b0, 1'b1};
        logic [30:0] a [3];
        logic [30:0] b [3];
        bit ev;
        for (int i = 0; i < 3; i++) begin
            a[i] = 31'($urandom_range(1, 32'h7FFF_FFFE));
            b[i] = 31'($urandom_range(1, 32'h7FFF_FFFE));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ev = i >= 2 && i < 5 && va[i-2];
            if (ev) held = ref_mul(a[i-2], b[i-2]);
            total++;
            if (out_if.out_valid !== ev || out_if.out !== held)
                $display("FAIL bubble_c%0d: got valid=%0b out=%0d, expected valid=%0b out=%0d",
                         i, out_if.out_valid, out_if.out, ev, held);
            else passed++;
            if (i < 3) drive(va[i], a[i], b[i]);
            else drive(1'b0, '0, '0);
        end
    endtask

    task automatic test_reset_midflight();
        logic [30:0] x, y;
        bit ev;
        x = 31'($urandom_range(2, 32'h7FFF_FFFE));
        y = 31'($urandom_range(2, 32'h7FFF_FFFE));
        @(negedge clk);
        drive(1'b1, rnd_op(), rnd_op());
        @(negedge clk);
        drive(1'b1, rnd_op(), rnd_op());
        rst = 1'b1;
        #1;
        total++;
        if (out_if.out_valid !== 1'b0 || out_if.out !== 62'd0)
            $display("FAIL midreset_async: got valid=%0b out=%0d, expected valid=0 out=0", out_if.out_valid, out_if.out);
        else passed++;
        held = '0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ev = i == 5;
            if (ev) held = ref_mul(x, y);
            total++;
            if (out_if.out_valid !== ev || out_if.out !== held)
                $display("FAIL midreset_c%0d: got valid=%0b out=%0d, expected valid=%0b out=%0d",
                         i, out_if.out_valid, out_if.out, ev, held);
            else passed++;
            if (i == 3) drive(1'b1, x, y);
            else drive(1'b0, '0, '0);
        end
    endtask

    task automatic test_random();
        bit vq [$];
        logic [61:0] eq [$];
        bit v;
        logic [61:0] e;
        logic [30:0] a, b;
        vq = '{1'b0, 1'b0};
        eq = '{62'd0, 62'd0};
        for (int i = 0; i < N_RAND + 2; i++) begin
            @(negedge clk);
            v = vq.pop_front();
            e = eq.pop_front();
            if (v) held = e;
            total++;
            if (out_if.out_valid !== v || out_if.out !== held)
                $display("FAIL random_c%0d: got valid=%0b out=%0d, expected valid=%0b out=%0d",
                         i, out_if.out_valid, out_if.out, v, held);
            else passed++;
            a = rnd_op();
            b = rnd_op();
            v = i < N_RAND && $urandom_range(0, 3) != 0;
            drive(v, a, b);
            vq.push_back(v);
            eq.push_back(ref_mul(a, b));
        end
    endtask

    initial begin
        drive(1'b0, '0, '0);
        test_reset();
        test_single();
        test_boundary();
        test_back_to_back();
        test_bubble();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
